// File: rtl/arith_muldiv_seq_pkg.sv
// Shared definitions for the iterative MULT/MULTU/DIV/DIVU sequencer.
//   op_e      : operation encodings as presented on the op port
//   state_e   : sequencer FSM states
//   ITER_LAST : final value of the iteration counter
//   FT_ADD/FT_SUB : function select for the shared add/sub unit
package arith_muldiv_seq_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      StIdle,
      StPrepA,
      StPrepB,
      StIter,
      StFixLo,
      StFixHi,
      StDone
   } state_e;

   localparam int unsigned ITER_LAST = 31;

   localparam logic FT_ADD = 1'b0;
   localparam logic FT_SUB = 1'b1;

endpackage

// File: rtl/arith_muldiv_seq_arith.sv
// Single add/sub unit shared by every step of the sequencer.
//   a, b        : operands
//   ft          : FT_ADD (a+b) or FT_SUB (a-b)
//   signed_mode : 1 -> overflow is two's-complement overflow,
//                 0 -> overflow is carry (add) or borrow (sub)
//   s           : result
//   zero        : s == 0
//   overflow    : see signed_mode
//   negative    : s[WIDTH-1]
module arith_muldiv_seq_arith
   import arith_muldiv_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ft,
   input  logic             signed_mode,
   output logic [WIDTH-1:0] s,
   output logic             zero,
   output logic             overflow,
   output logic             negative
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic             carry;
   logic             signed_ov;

   always_comb begin
      b_eff     = (ft == FT_SUB) ? ~b : b;
      sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ft};
      s         = sum[WIDTH-1:0];
      carry     = sum[WIDTH];
      signed_ov = (a[WIDTH-1] == b_eff[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
      zero      = (s == '0);
      negative  = s[WIDTH-1];
      // Subtraction borrow is the inverted carry of a + ~b + 1.
      if (signed_mode) begin
         overflow = signed_ov;
      end else begin
         overflow = (ft == FT_SUB) ? ~carry : carry;
      end
   end

endmodule

// File: rtl/arith_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer writing a HI/LO result pair.
// Every op takes 37 busy cycles: sign-strip a, sign-strip b, 32 shift/add or
// shift/subtract steps, fix LO sign, fix HI sign, done.
//   clk, rst_n    : clock, async active-low reset
//   start         : request, accepted only in idle
//   op, a, b      : operation and operands, sampled with an accepted start
//   busy          : high from the accepting edge until done exits
//   done          : one-cycle pulse, hi/lo/div_by_zero valid
//   hi, lo        : result, held until the next done
//   div_by_zero   : divide with b == 0, held with hi/lo
module arith_muldiv_seq
   import arith_muldiv_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             sa_q, sa_d, sb_q, sb_d;
   logic             lz_q, lz_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] hi_out_q, lo_out_q;
   logic             dbz_out_q;

   logic [WIDTH-1:0] ar_a, ar_b, ar_s;
   logic             ar_ft, ar_zero, ar_ov;
   logic             unused_negative;

   logic             is_div, is_signed_req;
   logic [WIDTH-1:0] rem_sh, b_abs;
   logic             q_bit;

   arith_muldiv_seq_arith #(
      .WIDTH (WIDTH)
   ) u_arith (
      .a           (ar_a),
      .b           (ar_b),
      .ft          (ar_ft),
      .signed_mode (1'b0),
      .s           (ar_s),
      .zero        (ar_zero),
      .overflow    (ar_ov),
      .negative    (unused_negative)
   );

   assign is_div        = (op_q == OP_DIV) || (op_q == OP_DIVU);
   assign is_signed_req = (op_e'(op) == OP_MULT) || (op_e'(op) == OP_DIV);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      lz_d    = lz_q;
      dbz_d   = dbz_q;
      ar_a    = '0;
      ar_b    = '0;
      ar_ft   = FT_ADD;
      rem_sh  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      b_abs   = b_q;
      q_bit   = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (start) begin
               state_d = StPrepA;
               op_d    = op_e'(op);
               a_d     = a;
               b_d     = b;
               // Sign flags are zero for unsigned ops so later fix-ups reduce to sa^sb / sa.
               sa_d    = is_signed_req & a[WIDTH-1];
               sb_d    = is_signed_req & b[WIDTH-1];
               dbz_d   = op[1] & (b == '0);
            end
         end
         StPrepA: begin
            ar_b  = a_q;
            ar_ft = FT_SUB;
            if (sa_q) a_d = ar_s;
            state_d = StPrepB;
         end
         StPrepB: begin
            ar_b  = b_q;
            ar_ft = FT_SUB;
            b_abs = sb_q ? ar_s : b_q;
            b_d   = b_abs;
            hi_d  = '0;
            lo_d  = is_div ? a_q : b_abs;
            state_d = StIter;
         end
         StIter: begin
            if (is_div) begin
               ar_a  = rem_sh;
               ar_b  = b_q;
               ar_ft = FT_SUB;
               // hi[31] set means the shifted remainder exceeds 32 bits, so it always fits.
               q_bit = hi_q[WIDTH-1] | ~ar_ov;
               hi_d  = q_bit ? ar_s : rem_sh;
               lo_d  = {lo_q[WIDTH-2:0], q_bit};
            end else begin
               ar_a  = hi_q;
               ar_b  = a_q;
               ar_ft = FT_ADD;
               if (lo_q[0]) begin
                  {hi_d, lo_d} = {ar_ov, ar_s, lo_q[WIDTH-1:1]};
               end else begin
                  {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
               end
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITER_LAST)) state_d = StFixLo;
         end
         StFixLo: begin
            ar_b  = lo_q;
            ar_ft = FT_SUB;
            if (sa_q ^ sb_q) lo_d = ar_s;
            // A zero low word means the 64-bit negate carries into hi.
            lz_d  = ar_zero;
            state_d = StFixHi;
         end
         StFixHi: begin
            ar_b  = hi_q;
            ar_ft = FT_SUB;
            if (!is_div && (sa_q ^ sb_q)) begin
               hi_d = lz_q ? ar_s : ~hi_q;
            end else if (is_div && sa_q) begin
               hi_d = ar_s;
            end
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         op_q      <= OP_MULT;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         sa_q      <= 1'b0;
         sb_q      <= 1'b0;
         lz_q      <= 1'b0;
         dbz_q     <= 1'b0;
         hi_out_q  <= '0;
         lo_out_q  <= '0;
         dbz_out_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         lz_q    <= lz_d;
         dbz_q   <= dbz_d;
         // Visible result only changes on the FIX_HI -> DONE edge.
         if (state_q == StFixHi) begin
            hi_out_q  <= hi_d;
            lo_out_q  <= lo_d;
            dbz_out_q <= dbz_q;
         end
      end
   end

   assign busy        = (state_q != StIdle);
   assign done        = (state_q == StDone);
   assign hi          = hi_out_q;
   assign lo          = lo_out_q;
   assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_arith_muldiv_seq.sv
// Directed-vector bench for arith_muldiv_seq.
module tb_arith_muldiv_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;

   int checks;
   int failures;
   logic [31:0] prev_hi;
   logic [31:0] prev_lo;

   arith_muldiv_seq #(
      .WIDTH (32),
      .CNT_W (6)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Issue one op, optionally with ignored start pulses while busy and in DONE.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                         input logic ed, input bit interfere);
      int n;
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = 32'h0000_0002;
      b     = 32'h0000_0003;
      op    = 2'd1;
      n     = 0;
      while (n < 60) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) check_eq({tag, ".busy"}, {31'b0, busy}, 32'd1);
         if (interfere && n == 5) start = 1'b1;
         if (interfere && n == 6) start = 1'b0;
         if (n == 10) begin
            check_eq({tag, ".hold_hi"}, hi, prev_hi);
            check_eq({tag, ".hold_lo"}, lo, prev_lo);
         end
         if (done) break;
      end
      check_eq({tag, ".latency"}, n, 32'd36);
      check_eq({tag, ".hi"}, hi, eh);
      check_eq({tag, ".lo"}, lo, el);
      check_eq({tag, ".dbz"}, {31'b0, div_by_zero}, {31'b0, ed});
      if (interfere) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_eq({tag, ".idle_after"}, {30'b0, busy, done}, 32'd0);
      check_eq({tag, ".held_lo"}, lo, el);
      prev_hi = eh;
      prev_lo = el;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      prev_hi  = 32'h0;
      prev_lo  = 32'h0;
      rst_n    = 1'b1;
      start    = 1'b0;
      op       = 2'd0;
      a        = 32'h0;
      b        = 32'h0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst.busy", {31'b0, busy}, 32'd0);
      check_eq("rst.done", {31'b0, done}, 32'd0);
      check_eq("rst.hi", hi, 32'h0);
      check_eq("rst.lo", lo, 32'h0);
      check_eq("rst.dbz", {31'b0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
             1'b0, 1'b0);
      run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
             1'b0, 1'b0);
      run_op("mult_min", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000,
             1'b0, 1'b0);
      run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
             1'b0, 1'b0);
      run_op("divu", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
      run_op("divu_zero", 2'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op("div_min", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000,
             1'b0, 1'b0);
      run_op("busy_ign", 2'd3, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0, 1'b1);
      run_op("b2b", 2'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006,
             1'b0, 1'b0);

      // Async reset in the middle of ITER (count 10 after edge 12).
      @(negedge clk);
      start = 1'b1;
      op    = 2'd1;
      a     = 32'h1234_5678;
      b     = 32'h9ABC_DEF0;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("midrst.busy", {31'b0, busy}, 32'd0);
      check_eq("midrst.hi", hi, 32'h0);
      check_eq("midrst.lo", lo, 32'h0);
      @(negedge clk);
      rst_n   = 1'b1;
      prev_hi = 32'h0;
      prev_lo = 32'h0;
      run_op("after_rst", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
